// File: rtl/lsu_bus_master.sv
// Load/store initiator: turns core lb/lh/lw/lbu/lhu/sb/sh/sw requests into word-aligned bus beats,
// splitting accesses that cross a word boundary and extending load data.
`timescale 1ns/1ps
module lsu_bus_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter logic [31:0] LIMIT_ADDR = 32'h1001_FFFF,
  parameter bit          SPLIT_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1, StResp, StFault} state_e;

  state_e      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        split_q;
  logic [31:0] rdata0_q;
  logic [3:0]  be1_q;
  logic [31:0] wdata1_q;

  // Request decode, evaluated on the incoming request at accept time.
  logic [2:0]  size;
  logic [3:0]  mask;
  logic [32:0] end_addr;
  logic [3:0]  span;
  logic        split_need;
  logic        funct3_bad;
  logic        range_bad;
  logic        fault;
  logic [7:0]  be64;
  logic [63:0] d64;

  always_comb begin
    size = 3'd4;
    mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00:   begin size = 3'd1; mask = 4'b0001; end
      2'b01:   begin size = 3'd2; mask = 4'b0011; end
      default: begin size = 3'd4; mask = 4'b1111; end
    endcase
    end_addr   = {1'b0, req_addr} + 33'(size) - 33'd1;
    span       = 4'(req_addr[1:0]) + 4'(size);
    split_need = (span > 4'd4);
    if (req_we) funct3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else        funct3_bad = (req_funct3 inside {3'b011, 3'b110, 3'b111});
    range_bad  = (req_addr < BASE_ADDR) || (end_addr > {1'b0, LIMIT_ADDR});
    fault      = funct3_bad || range_bad || (split_need && !SPLIT_EN);
    be64       = 8'(mask) << req_addr[1:0];
    d64        = 64'(req_wdata) << {req_addr[1:0], 3'b000};
  end

  // Load result: the upper word is only meaningful when finishing the second beat.
  logic [63:0] ld64;
  logic [31:0] ld_x;
  logic [31:0] load_ext;

  always_comb begin
    ld64 = (state == StWait1) ? {mem_rdata, rdata0_q} : {32'b0, mem_rdata};
    ld_x = 32'(ld64 >> {off_q, 3'b000});
    case (funct3_q)
      3'b000:  load_ext = {{24{ld_x[7]}}, ld_x[7:0]};
      3'b001:  load_ext = {{16{ld_x[15]}}, ld_x[15:0]};
      3'b100:  load_ext = {24'b0, ld_x[7:0]};
      3'b101:  load_ext = {16'b0, ld_x[15:0]};
      default: load_ext = ld_x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      split_q   <= 1'b0;
      rdata0_q  <= '0;
      be1_q     <= '0;
      wdata1_q  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        StIdle: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            off_q     <= req_addr[1:0];
            split_q   <= split_need;
            be1_q     <= be64[7:4];
            wdata1_q  <= d64[63:32];
            if (fault) begin
              state     <= StFault;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
            end else begin
              state     <= StReq0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= req_we ? be64[3:0] : 4'b1111;
              mem_wdata <= req_we ? d64[31:0] : 32'b0;
            end
          end
        end
        StReq0: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= StWait0;
          end
        end
        StWait0: begin
          if (mem_rvalid) begin
            rdata0_q <= mem_rdata;
            if (split_q) begin
              state     <= StReq1;
              mem_req   <= 1'b1;
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= we_q ? be1_q : 4'b1111;
              mem_wdata <= we_q ? wdata1_q : 32'b0;
            end else begin
              state     <= StResp;
              rsp_valid <= 1'b1;
              rsp_rdata <= we_q ? 32'b0 : load_ext;
            end
          end
        end
        StReq1: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= StWait1;
          end
        end
        StWait1: begin
          if (mem_rvalid) begin
            state     <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? 32'b0 : load_ext;
          end
        end
        StResp, StFault: begin
          state     <= StIdle;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= StIdle;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: a word memory responder checks each granted beat against
// a queue of expected beats, and a response monitor checks each rsp_valid pulse.
`timescale 1ns/1ps
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu_bus_master dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic fault; logic [31:0] rdata; int lat; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } beat_t;

  rsp_t        rsp_q[$];
  beat_t       beat_q[$];
  int          checks = 0;
  int          failures = 0;
  int          rsp_cnt = 0;
  int          beat_cnt = 0;
  int          gnt_delay = 0;
  int          rv_delay = 0;
  time         t_issue = 0;
  logic [31:0] mem_arr [16];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void expect_beat(logic we, logic [31:0] addr, logic [3:0] be,
                                      logic [31:0] wdata);
    beat_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
    beat_q.push_back(b);
  endfunction

  // Response monitor.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rsp_valid) begin
      rsp_cnt++;
      chk("ready_low_during_rsp", {31'b0, req_ready}, 32'd0);
      if (rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got fault=%b rdata=%h expected none", rsp_fault, rsp_rdata);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
        chk("rsp_rdata", rsp_rdata, e.rdata);
        if (e.lat >= 0) chk("rsp_latency", 32'(($time - t_issue) / 10), 32'(e.lat));
      end
    end
  end

  // Word memory responder: grants after gnt_delay waiting cycles, rvalid 1+rv_delay cycles later.
  logic        waiting = 1'b0;
  logic        unstable = 1'b0;
  int          wait_cnt = 0;
  int          rv_cnt = 0;
  logic [68:0] cap;
  logic [31:0] rv_data;

  initial begin
    beat_t e;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
        end
      end
      if (mem_req && !rst) begin
        if (!waiting) begin
          waiting = 1'b1; wait_cnt = 0; unstable = 1'b0;
          cap = {mem_we, mem_addr, mem_be, mem_wdata};
        end else if (cap !== {mem_we, mem_addr, mem_be, mem_wdata}) begin
          unstable = 1'b1;
        end
        if (wait_cnt >= gnt_delay) begin
          mem_gnt = 1'b1;
          waiting = 1'b0;
          beat_cnt++;
          chk("beat_stable", {31'b0, unstable}, 32'd0);
          if (beat_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got addr=%h we=%b be=%b expected none",
                     mem_addr, mem_we, mem_be);
          end else begin
            e = beat_q.pop_front();
            chk("beat_we", {31'b0, mem_we}, {31'b0, e.we});
            chk("beat_addr", mem_addr, e.addr);
            chk("beat_be", {28'b0, mem_be}, {28'b0, e.be});
            if (e.we) chk("beat_wdata", mem_wdata, e.wdata);
          end
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) mem_arr[mem_addr[5:2]][8*i +: 8] = mem_wdata[8*i +: 8];
          end
          rv_data = mem_arr[mem_addr[5:2]];
          rv_cnt  = 1 + rv_delay;
        end else begin
          wait_cnt++;
        end
      end else begin
        waiting = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    t_issue = $time;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int nbeats, input logic efault,
                        input logic [31:0] erdata, input int lat);
    int   b0, r0, n;
    rsp_t r;
    wait_ready();
    b0 = beat_cnt; r0 = rsp_cnt;
    r.fault = efault; r.rdata = erdata; r.lat = lat;
    rsp_q.push_back(r);
    drive_req(we, f3, addr, wdata);
    n = 0;
    while (rsp_cnt == r0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("rsp_count", 32'(rsp_cnt - r0), 32'd1);
    chk("beat_count", 32'(beat_cnt - b0), 32'(nbeats));
    chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
    if (rsp_cnt == r0) rsp_q.delete();
    beat_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r0, n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) mem_arr[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // sw then lw back
    expect_beat(1'b1, 32'h1001_0000, 4'b1111, 32'hDEAD_BEEF);
    run_op(1'b1, 3'b010, 32'h1001_0000, 32'hDEAD_BEEF, 1, 1'b0, 32'h0, 3);
    expect_beat(1'b0, 32'h1001_0000, 4'b1111, 32'h0);
    run_op(1'b0, 3'b010, 32'h1001_0000, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 3);

    // lb / lbu of top byte
    mem_arr[0] = 32'h80FF_0000;
    expect_beat(1'b0, 32'h1001_0000, 4'b1111, 32'h0);
    run_op(1'b0, 3'b000, 32'h1001_0003, 32'h0, 1, 1'b0, 32'hFFFF_FF80, 3);
    expect_beat(1'b0, 32'h1001_0000, 4'b1111, 32'h0);
    run_op(1'b0, 3'b100, 32'h1001_0003, 32'h0, 1, 1'b0, 32'h0000_0080, 3);

    // split sh, then read both words back
    mem_arr[1] = 32'h0;
    expect_beat(1'b1, 32'h1001_0000, 4'b1000, 32'hCD00_0000);
    expect_beat(1'b1, 32'h1001_0004, 4'b0001, 32'h0000_00AB);
    run_op(1'b1, 3'b001, 32'h1001_0003, 32'h0000_ABCD, 2, 1'b0, 32'h0, 5);
    expect_beat(1'b0, 32'h1001_0000, 4'b1111, 32'h0);
    run_op(1'b0, 3'b010, 32'h1001_0000, 32'h0, 1, 1'b0, 32'hCDFF_0000, 3);
    expect_beat(1'b0, 32'h1001_0004, 4'b1111, 32'h0);
    run_op(1'b0, 3'b010, 32'h1001_0004, 32'h0, 1, 1'b0, 32'h0000_00AB, 3);

    // split lw, lh/lhu variants
    mem_arr[0] = 32'h4433_2211;
    mem_arr[1] = 32'h8877_6655;
    expect_beat(1'b0, 32'h1001_0000, 4'b1111, 32'h0);
    expect_beat(1'b0, 32'h1001_0004, 4'b1111, 32'h0);
    run_op(1'b0, 3'b010, 32'h1001_0002, 32'h0, 2, 1'b0, 32'h6655_4433, 5);
    expect_beat(1'b0, 32'h1001_0000, 4'b1111, 32'h0);
    run_op(1'b0, 3'b001, 32'h1001_0001, 32'h0, 1, 1'b0, 32'h0000_3322, 3);
    expect_beat(1'b0, 32'h1001_0000, 4'b1111, 32'h0);
    expect_beat(1'b0, 32'h1001_0004, 4'b1111, 32'h0);
    run_op(1'b0, 3'b101, 32'h1001_0003, 32'h0, 2, 1'b0, 32'h0000_5544, 5);
    expect_beat(1'b0, 32'h1001_0004, 4'b1111, 32'h0);
    run_op(1'b0, 3'b001, 32'h1001_0006, 32'h0, 1, 1'b0, 32'hFFFF_8877, 3);

    // sb into lane 1
    expect_beat(1'b1, 32'h1001_0004, 4'b0010, 32'h0000_5A00);
    run_op(1'b1, 3'b000, 32'h1001_0005, 32'h0000_005A, 1, 1'b0, 32'h0, 3);
    expect_beat(1'b0, 32'h1001_0004, 4'b1111, 32'h0);
    run_op(1'b0, 3'b010, 32'h1001_0004, 32'h0, 1, 1'b0, 32'h8877_5A55, 3);

    // last legal byte
    mem_arr[15] = 32'h7F00_0000;
    expect_beat(1'b0, 32'h1001_FFFC, 4'b1111, 32'h0);
    run_op(1'b0, 3'b000, 32'h1001_FFFF, 32'h0, 1, 1'b0, 32'h0000_007F, 3);

    // faults: no bus traffic, response one cycle after accept
    run_op(1'b0, 3'b010, 32'h1001_FFFE, 32'h0, 0, 1'b1, 32'h0, 1);
    run_op(1'b0, 3'b000, 32'h1000_FFFF, 32'h0, 0, 1'b1, 32'h0, 1);
    run_op(1'b0, 3'b011, 32'h1001_0000, 32'h0, 0, 1'b1, 32'h0, 1);
    run_op(1'b1, 3'b100, 32'h1001_0000, 32'h1234, 0, 1'b1, 32'h0, 1);
    run_op(1'b0, 3'b001, 32'h1001_FFFF, 32'h0, 0, 1'b1, 32'h0, 1);

    // grant held off five cycles
    gnt_delay = 5;
    expect_beat(1'b1, 32'h1001_0008, 4'b1111, 32'h1234_5678);
    run_op(1'b1, 3'b010, 32'h1001_0008, 32'h1234_5678, 1, 1'b0, 32'h0, 8);
    gnt_delay = 0;
    expect_beat(1'b0, 32'h1001_0008, 4'b1111, 32'h0);
    run_op(1'b0, 3'b010, 32'h1001_0008, 32'h0, 1, 1'b0, 32'h1234_5678, 3);

    // reset while waiting for read data: no response, back to idle
    rv_delay = 4;
    wait_ready();
    r0 = rsp_cnt;
    n = beat_cnt;
    expect_beat(1'b0, 32'h1001_0000, 4'b1111, 32'h0);
    drive_req(1'b0, 3'b010, 32'h1001_0000, 32'h0);
    for (int i = 0; i < 10 && beat_cnt == n; i++) @(posedge clk);
    chk("rst_test_beat", 32'(beat_cnt - n), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (10) @(posedge clk);
    chk("midrst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    rv_delay = 0;

    expect_beat(1'b0, 32'h1001_0000, 4'b1111, 32'h0);
    run_op(1'b0, 3'b010, 32'h1001_0000, 32'h0, 1, 1'b0, 32'h4433_2211, 3);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
